// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [1:0] digit_t;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } slot_state_t;

   // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   // Table lookup of the glyph for the selected nibble.
   always_comb begin
      o_seg = SEG_TABLE[i_nib];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous shadow load.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_BLANK | first BLANK_CYC cycles of a slot, anodes off
//  ST_ON    | remainder of the slot, selected digit driven
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int TICK_DIV    = 3000,
   parameter int BLANK_CYC   = 16,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       clr,
   output digit_t     sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       frame_done
);

   localparam int              CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYC);
   localparam slot_state_t     ST_RESET  = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   digit_t        r_sel;
   slot_state_t   r_state;
   slot_state_t   w_state_nxt;
   logic [15:0]   r_pending;
   logic [15:0]   r_shadow;
   logic          w_tc;
   logic          w_wrap;
   logic [3:0]    w_nib;
   logic [6:0]    w_glyph;
   logic          w_lz_blank;

   // Slot counter next value and the BLANK/ON state that goes with it.
   always_comb begin
      w_tc        = (r_cnt == CNT_MAX);
      w_wrap      = w_tc && (r_sel == 2'd3);
      w_cnt_nxt   = w_tc ? '0 : r_cnt + 1'b1;
      w_state_nxt = (w_cnt_nxt < BLANK_LIM) ? ST_BLANK : ST_ON;
   end

   // Slot counter, digit index and FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_sel   <= '0;
         r_state <= ST_RESET;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
         if (w_tc) r_sel <= r_sel + 2'd1;
      end
   end

   // Pending byte-shift buffer and frame-boundary shadow transfer; clr beats wr_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= '0;
         r_shadow   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_wrap;
         if (w_wrap) r_shadow <= r_pending;
         if (clr)        r_pending <= '0;
         else if (wr_en) r_pending <= {r_pending[7:0], wr_data};
      end
   end

   // Leading-zero blanking of the digit currently selected.
   always_comb begin
      w_lz_blank = 1'b0;
      if (LZ_SUPPRESS != 0) begin
         case (r_sel)
            2'd1:    w_lz_blank = (r_shadow[15:4]  == 12'h000);
            2'd2:    w_lz_blank = (r_shadow[15:8]  == 8'h00);
            2'd3:    w_lz_blank = (r_shadow[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
         endcase
      end
   end

   assign w_nib = r_shadow[{r_sel, 2'b00} +: 4];
   assign sel   = r_sel;

   hex7seg u_hex7seg (
      .i_nib (w_nib),
      .o_seg (w_glyph)
   );

   // Registered anode and segment drive, one cycle behind sel and state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else if ((r_state == ST_BLANK) || w_lz_blank) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(4'b0001 << r_sel);
         seg <= w_glyph;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: two instances (leading-zero suppression off / on) share stimulus.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       clr = 1'b0;

   logic [1:0] sel0, sel1;
   logic [3:0] an0, an1;
   logic [6:0] seg0, seg1;
   logic       fd0, fd1;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] g_an0 [4];
   logic [3:0] g_an1 [4];
   logic [6:0] g_seg0 [4];
   logic [6:0] g_seg1 [4];

   seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2), .LZ_SUPPRESS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
      .sel(sel0), .an(an0), .seg(seg0), .frame_done(fd0)
   );

   seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2), .LZ_SUPPRESS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
      .sel(sel1), .an(an1), .seg(seg1), .frame_done(fd1)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_fd();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fd0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("frame_done_seen", {31'd0, seen}, 32'd1);
   endtask

   // Called on the negedge where frame_done is high; samples each slot at cnt=4.
   task automatic grab();
      for (int d = 0; d < 4; d++) begin
         repeat ((d == 0) ? 4 : 8) @(negedge clk);
         g_an0[d]  = an0;
         g_seg0[d] = seg0;
         g_an1[d]  = an1;
         g_seg1[d] = seg1;
      end
   endtask

   task automatic chk_frame(input string tag, input logic [15:0] val, input logic [3:0] lz_mask);
      logic [3:0] ea;
      logic [6:0] es;
      for (int d = 0; d < 4; d++) begin
         ea = ~(4'b0001 << d);
         es = glyph(val[4*d +: 4]);
         chk({tag, "_an0"},  {28'd0, g_an0[d]},  {28'd0, ea});
         chk({tag, "_seg0"}, {25'd0, g_seg0[d]}, {25'd0, es});
         chk({tag, "_an1"},  {28'd0, g_an1[d]},  lz_mask[d] ? 32'hF  : {28'd0, ea});
         chk({tag, "_seg1"}, {25'd0, g_seg1[d]}, lz_mask[d] ? 32'h7F : {25'd0, es});
      end
   endtask

   initial begin
      logic [3:0] ea0;
      logic [3:0] ea1;
      logic [6:0] es0;
      logic       blank;
      int         pc, ps;

      // Reset asserted mid-slot, away from any clock edge.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (13) @(negedge clk);
      chk("pre_rst_an0", {28'd0, an0}, 32'hD);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_an0",  {28'd0, an0},  32'hF);
      chk("rst_seg0", {25'd0, seg0}, 32'h7F);
      chk("rst_sel0", {30'd0, sel0}, 32'd0);
      chk("rst_fd0",  {31'd0, fd0},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scan timing over two frames plus a bit, from cnt=0 after release.
      for (int k = 1; k <= 66; k++) begin
         @(negedge clk);
         pc    = (k - 1) % 8;
         ps    = ((k - 1) / 8) % 4;
         blank = (pc < 2);
         ea0   = blank ? 4'hF : ~(4'b0001 << ps);
         es0   = blank ? 7'h7F : 7'h40;
         ea1   = (blank || ps != 0) ? 4'hF : 4'hE;
         chk("scan_sel",  {30'd0, sel0}, (k / 8) % 4);
         chk("scan_fd",   {31'd0, fd0},  (k % 32 == 0) ? 32'd1 : 32'd0);
         chk("scan_an0",  {28'd0, an0},  {28'd0, ea0});
         chk("scan_seg0", {25'd0, seg0}, {25'd0, es0});
         chk("scan_an1",  {28'd0, an1},  {28'd0, ea1});
      end

      // Load 0x12, 0x34 mid-frame; the current frame keeps showing zeros.
      wr_en = 1'b1; wr_data = 8'h12;
      @(negedge clk);
      wr_data = 8'h34;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (24) @(negedge clk);
      chk("load_old_an0",  {28'd0, an0},  32'h7);
      chk("load_old_seg0", {25'd0, seg0}, 32'h40);
      chk("load_old_an1",  {28'd0, an1},  32'hF);
      wait_fd();
      grab();
      chk_frame("load", 16'h1234, 4'b0000);

      // Leading zero: clr then 0x05, then clr alone.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0; wr_en = 1'b1; wr_data = 8'h05;
      @(negedge clk);
      wr_en = 1'b0;
      wait_fd();
      grab();
      chk_frame("lz5", 16'h0005, 4'b1110);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      wait_fd();
      grab();
      chk_frame("lzclr", 16'h0000, 4'b1110);

      // clr and wr_en together: byte dropped.
      wr_en = 1'b1; wr_data = 8'h77;
      @(negedge clk);
      clr = 1'b1; wr_data = 8'hAB;
      @(negedge clk);
      clr = 1'b0; wr_en = 1'b0;
      chk("coll_pending", {16'd0, dut0.r_pending}, 32'h0000);
      wait_fd();
      grab();
      chk_frame("coll", 16'h0000, 4'b1110);

      // Write in the wrap cycle: shows one frame later.
      repeat (3) @(negedge clk);
      chk("wrapw_pre_sel", {30'd0, sel0}, 32'd3);
      wr_en = 1'b1; wr_data = 8'h9C;
      @(negedge clk);
      wr_en = 1'b0;
      chk("wrapw_fd", {31'd0, fd0}, 32'd1);
      grab();
      chk_frame("wrapw_old", 16'h0000, 4'b1110);
      wait_fd();
      grab();
      chk_frame("wrapw_new", 16'h009C, 4'b1100);

      // Back-to-back writes DE, AD, BE.
      wr_en = 1'b1; wr_data = 8'hDE;
      @(negedge clk);
      wr_data = 8'hAD;
      @(negedge clk);
      wr_data = 8'hBE;
      @(negedge clk);
      wr_en = 1'b0;
      chk("b2b_pending", {16'd0, dut0.r_pending}, 32'hADBE);
      wait_fd();
      grab();
      chk_frame("b2b", 16'hADBE, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Four-digit seven-segment scan controller for the UART front panel. Accepts received bytes as two hex digits each, holds them in a pending buffer, and transfers the buffer to a display shadow only at frame boundaries so a scan never shows a torn value. Drives the digit selector with a programmable per-digit period and a blanking gap between digits, with optional leading-zero suppression. Sits between the UART receiver and the board's common-anode display.

## Interface
- `TICK_DIV`, default 3000: clock cycles per digit slot. Legal range is 2 or more.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off. Legal range is 0 to `TICK_DIV-1`.
- `LZ_SUPPRESS`, default 1: when 1, blank leading zero digits.
- `clk`, input, 1 bit: system clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `wr_en`, input, 1 bit: single-cycle write strobe from the UART receiver.
- `wr_data`, input, 8 bits: byte to shift in. Upper nibble lands on digit 1, lower nibble on digit 0.
- `clr`, input, 1 bit: clear the pending buffer to 0x0000.
- `sel`, output, 2 bits: current digit index, 0 to 3.
- `an`, output, 4 bits: anode enables, active-low, registered.
- `seg`, output, 7 bits: segments a–g, active-low, registered.
- `frame_done`, output, 1 bit: one-cycle pulse on each wrap from digit 3 to digit 0.

## Operation
- Slot counter `cnt` counts 0 to `TICK_DIV-1`.
  - At `TICK_DIV-1`: `cnt` returns to 0 and `sel` increments, wrapping from 3 to 0.
- Per-slot FSM has two states, derived from `cnt`:
  - BLANK while `cnt < BLANK_CYC`.
  - ON otherwise.
  - With `BLANK_CYC=0`, the FSM never enters BLANK.
- Pending buffer is 16 bits.
  - `wr_en`: pending becomes pending[7:0] followed by `wr_data`.
  - `clr`: pending becomes 0.
  - `clr` and `wr_en` in the same cycle: `clr` wins and the byte is dropped.
- Shadow transfer: on the cycle `sel` wraps from 3 to 0, shadow is loaded from pending and `frame_done` pulses.
  - A write in that same cycle is not captured. It appears on the following frame.
- Digit select: the nibble shown is `shadow[4*sel +: 4]`, decoded to hex 0–F glyphs.
- Leading-zero suppression (`LZ_SUPPRESS=1`): digit k is blanked when digits k through 3 of shadow are all zero and k is not 0.
  - Digit 0 is always shown, so 0x0000 displays "0".
- Blanked digit and BLANK state both drive `an`=1111 and `seg`=1111111.
- Otherwise `an` is active-low one-hot at bit `sel`.

## Timing
- Reset, applied asynchronously: `cnt`=0, `sel`=0, FSM in BLANK (or ON if `BLANK_CYC=0`), pending=0, shadow=0, `an`=1111, `seg`=1111111, `frame_done`=0.
- `an` and `seg` are registered, so they lag `sel` and the FSM state by one cycle.
- Digit slot is exactly `TICK_DIV` cycles; frame is exactly `4*TICK_DIV` cycles.
- Write-to-display latency:
  - Minimum is 1 cycle plus the time until the next wrap.
  - Maximum is `4*TICK_DIV+1` cycles.
- `frame_done` is asserted in the same cycle that `sel` reads 0 after the wrap.
- Reset mid-frame: the scan restarts at digit 0 with `cnt`=0. Pending data is lost.
- Back-to-back `wr_en` on consecutive cycles is legal. Each byte shifts in.

## Structure
- Shared package `seg_pkg` holds:
  - `SEG_BLANK` constant (7'h7F).
  - `AN_OFF` constant (4'hF).
  - Digit index typedef (2 bits).
  - Nibble-to-segment constant table.
- Sub-module `hex7seg`: purely combinational 4-bit to active-low 7-segment decoder, built from the package table. Instantiate it once.
- Counter, FSM, buffers and output registers live in `seg_scan_ctrl`.

## Test plan
- Reset: assert `rst_n`=0 mid-slot.
  - Required: `an`=1111, `seg`=7F, `sel`=0, `frame_done`=0 immediately.
  - Required after release: first non-blank `an`=1110 at `BLANK_CYC+1` cycles.
- Scan timing with `TICK_DIV`=8, `BLANK_CYC`=2:
  - `sel` must step every 8 cycles.
  - `an`=1111 for 2 cycles per slot.
  - `frame_done` must pulse every 32 cycles.
- Load: write 0x12 then 0x34, with `LZ_SUPPRESS`=0.
  - Required: after the next `frame_done`, digits 3..0 show 1, 2, 3, 4.
  - Required: the current frame shows the old value.
- Leading zero: write 0x05 with `LZ_SUPPRESS`=1.
  - Required: only `an[0]` goes low, showing "5".
  - Required: after `clr`, digit 0 shows "0".
- Collisions:
  - `clr` and `wr_en`=0xAB together: pending must read 0x0000.
  - `wr_en` in the wrap cycle: the value must appear one frame later.
- Back-to-back writes 0xDE, 0xAD, 0xBE:
  - Required: pending holds 0xADBE.
  - Required: display shows "AdbE" after the wrap.
